// File: rtl/bomb_ctrl.sv
// bomb_ctrl: single-bomb sequencer for a two-player tile game.
//
// Both players request bombs with drop levels; rising edges latch a pending
// flag per player. One bomb exists at a time: it sits on its tile for the
// fuse time, then a clamped 3x3-tile blast damages any player box touching
// it (at most one hit per player per blast), then a dead cool-down follows.
//
// Ports
//   frame_clk                 clock, one tick per video frame
//   Reset                     asynchronous, active low
//   drop1, drop2              bomb request levels per player
//   p1X, p1Y, p2X, p2Y        player top-left pixel positions (18x26 sprites)
//   bombX/Y, bombXS/YS        hazard rectangle origin and extent
//   armed, blast              phase indicators
//   owner                     0 = player 1, 1 = player 2
//   hit1, hit2                one-cycle damage pulses
//   heart1, heart2            remaining lives
//   game_over                 either heart counter at 0
//
// state | meaning
// IDLE  | no bomb; grants a pending request unless the game is over
// ARMED | bomb on its tile, fuse burning
// BLAST | 3x3-tile blast is lethal
// COOL  | dead frames before the next bomb may be granted
module bomb_ctrl #(
   parameter int FUSE_FRAMES  = 120,
   parameter int BLAST_FRAMES = 30,
   parameter int COOL_FRAMES  = 15,
   parameter int TILE         = 32
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       drop1,
   input  logic       drop2,
   input  logic [9:0] p1X,
   input  logic [9:0] p1Y,
   input  logic [9:0] p2X,
   input  logic [9:0] p2Y,
   output logic [9:0] bombX,
   output logic [9:0] bombY,
   output logic [9:0] bombXS,
   output logic [9:0] bombYS,
   output logic       armed,
   output logic       blast,
   output logic       owner,
   output logic       hit1,
   output logic       hit2,
   output logic [2:0] heart1,
   output logic [2:0] heart2,
   output logic       game_over
);

   typedef enum logic [1:0] {IDLE, ARMED, BLAST, COOL} state_t;

   localparam logic [9:0]  TILE_MASK = ~10'(TILE - 1);
   localparam logic [10:0] T1        = 11'(TILE);
   localparam logic [10:0] T2        = 11'(2 * TILE);
   localparam logic [10:0] T3        = 11'(3 * TILE);
   localparam logic [10:0] EDGE_MIN  = 11'd32;
   localparam logic [10:0] SPR_W     = 11'd18;
   localparam logic [10:0] SPR_H     = 11'd26;

   state_t      state, state_nxt;
   logic [15:0] cnt;
   logic        drop1_q, drop2_q;
   logic        pend1, pend2;
   logic        last_grant;
   logic        stick1, stick2;
   logic        grant1, grant2;
   logic        fire1, fire2;
   logic [9:0]  tile_x, tile_y;
   logic [10:0] tile_x11, tile_y11;
   logic [10:0] org_x, org_y, ext_x, ext_y;
   logic        over1, over2;

   assign game_over = (heart1 == 3'd0) || (heart2 == 3'd0);
   assign armed     = (state == ARMED);
   assign blast     = (state == BLAST);

   always_comb begin
      state_nxt = state;
      grant1    = 1'b0;
      grant2    = 1'b0;
      unique case (state)
         IDLE: begin
            if (!game_over) begin
               // On a tie the player not served last wins.
               if (pend1 && pend2) begin
                  grant1 = last_grant;
                  grant2 = ~last_grant;
               end else begin
                  grant1 = pend1;
                  grant2 = pend2;
               end
               if (pend1 || pend2) state_nxt = ARMED;
            end
         end
         ARMED: if (cnt == 16'(FUSE_FRAMES - 1))  state_nxt = BLAST;
         BLAST: if (cnt == 16'(BLAST_FRAMES - 1)) state_nxt = COOL;
         COOL:  if (cnt == 16'(COOL_FRAMES - 1))  state_nxt = IDLE;
      endcase
   end

   // Blast square, clamped at the low edge so the far edge never moves.
   always_comb begin
      tile_x11 = {1'b0, tile_x};
      tile_y11 = {1'b0, tile_y};
      org_x    = (tile_x11 < T1 + EDGE_MIN) ? EDGE_MIN : tile_x11 - T1;
      org_y    = (tile_y11 < T1 + EDGE_MIN) ? EDGE_MIN : tile_y11 - T1;
      ext_x    = (tile_x11 < T1 + EDGE_MIN) ? tile_x11 + T2 - EDGE_MIN : T3;
      ext_y    = (tile_y11 < T1 + EDGE_MIN) ? tile_y11 + T2 - EDGE_MIN : T3;
   end

   always_comb begin
      bombX  = '0;
      bombY  = '0;
      bombXS = '0;
      bombYS = '0;
      if (state == ARMED) begin
         bombX  = tile_x;
         bombY  = tile_y;
         bombXS = 10'(TILE);
         bombYS = 10'(TILE);
      end else if (state == BLAST) begin
         bombX  = org_x[9:0];
         bombY  = org_y[9:0];
         bombXS = ext_x[9:0];
         bombYS = ext_y[9:0];
      end
   end

   // 11-bit compares: sprite and blast far edges can pass 1023.
   always_comb begin
      over1 = ({1'b0, p1X} < org_x + ext_x) && (org_x < {1'b0, p1X} + SPR_W) &&
              ({1'b0, p1Y} < org_y + ext_y) && (org_y < {1'b0, p1Y} + SPR_H);
      over2 = ({1'b0, p2X} < org_x + ext_x) && (org_x < {1'b0, p2X} + SPR_W) &&
              ({1'b0, p2Y} < org_y + ext_y) && (org_y < {1'b0, p2Y} + SPR_H);
      fire1 = (state == BLAST) && over1 && !stick1;
      fire2 = (state == BLAST) && over2 && !stick2;
   end

   always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) begin
         state      <= IDLE;
         cnt        <= '0;
         drop1_q    <= 1'b0;
         drop2_q    <= 1'b0;
         pend1      <= 1'b0;
         pend2      <= 1'b0;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         tile_x     <= '0;
         tile_y     <= '0;
         stick1     <= 1'b0;
         stick2     <= 1'b0;
         hit1       <= 1'b0;
         hit2       <= 1'b0;
         heart1     <= 3'd3;
         heart2     <= 3'd3;
      end else begin
         state   <= state_nxt;
         cnt     <= (state_nxt != state) ? 16'd0 : cnt + 16'd1;
         drop1_q <= drop1;
         drop2_q <= drop2;
         // A pending flag ignores further edges until it is granted.
         pend1   <= pend1 ? ~grant1 : (drop1 & ~drop1_q);
         pend2   <= pend2 ? ~grant2 : (drop2 & ~drop2_q);
         if (grant1 || grant2) begin
            owner      <= grant2;
            last_grant <= grant2;
            tile_x     <= (grant2 ? p2X : p1X) & TILE_MASK;
            tile_y     <= (grant2 ? p2Y : p1Y) & TILE_MASK;
         end
         if (state_nxt == BLAST && state != BLAST) begin
            stick1 <= 1'b0;
            stick2 <= 1'b0;
         end
         hit1 <= fire1;
         hit2 <= fire2;
         if (fire1) begin
            stick1 <= 1'b1;
            if (heart1 != 3'd0) heart1 <= heart1 - 3'd1;
         end
         if (fire2) begin
            stick2 <= 1'b1;
            if (heart2 != 3'd0) heart2 <= heart2 - 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_bomb_ctrl.sv
// tb_bomb_ctrl: directed scenarios with randomized player positions for
// bomb_ctrl; expected rectangles, hits and hearts come from a geometric
// model of the game rules.
module tb_bomb_ctrl;

   localparam int FUSE = 120;
   localparam int BLST = 30;
   localparam int COOL = 15;

   logic       frame_clk = 1'b0;
   logic       Reset     = 1'b0;
   logic       drop1     = 1'b0;
   logic       drop2     = 1'b0;
   logic [9:0] p1X = '0, p1Y = '0, p2X = '0, p2Y = '0;
   logic [9:0] bombX, bombY, bombXS, bombYS;
   logic       armed, blast, owner, hit1, hit2, game_over;
   logic [2:0] heart1, heart2;

   int checks   = 0;
   int failures = 0;
   int h1 = 3, h2 = 3;

   bomb_ctrl dut (
      .frame_clk(frame_clk), .Reset(Reset), .drop1(drop1), .drop2(drop2),
      .p1X(p1X), .p1Y(p1Y), .p2X(p2X), .p2Y(p2Y),
      .bombX(bombX), .bombY(bombY), .bombXS(bombXS), .bombYS(bombYS),
      .armed(armed), .blast(blast), .owner(owner), .hit1(hit1), .hit2(hit2),
      .heart1(heart1), .heart2(heart2), .game_over(game_over)
   );

   always #5 frame_clk = ~frame_clk;

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int tile_of(input int p);
      return (p / 32) * 32;
   endfunction

   function automatic int borg(input int t);
      return (t - 32 < 32) ? 32 : t - 32;
   endfunction

   function automatic int bext(input int t);
      return t + 64 - borg(t);
   endfunction

   function automatic int touches(input int px, input int py, input int tx, input int ty);
      int bx, by;
      bx = borg(tx);
      by = borg(ty);
      return (px < bx + bext(tx) && bx < px + 18 && py < by + bext(ty) && by < py + 26) ? 1 : 0;
   endfunction

   task automatic tick();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b0;
      drop1 = 1'b0;
      drop2 = 1'b0;
      tick();
      tick();
      Reset = 1'b1;
      h1 = 3;
      h2 = 3;
      tick();
   endtask

   task automatic press(input logic d1, input logic d2);
      drop1 = d1;
      drop2 = d2;
      tick();
      drop1 = 1'b0;
      drop2 = 1'b0;
   endtask

   task automatic start_bomb(input logic d1, input logic d2);
      press(d1, d2);
      check("grant_wait", 32'(armed), 0);
      tick();
      check("grant_armed", 32'(armed), 1);
   endtask

   // Entered on an ARMED sample n0 cycles into the fuse; returns on the
   // IDLE sample that follows the cool-down.
   task automatic run_bomb(input int own, input int tx, input int ty, input int n0);
      int n, bad, nh1, nh2, e1, e2, bx, by, bw, bh;
      check("owner", 32'(owner), 32'(own));
      n = n0; bad = 0; nh1 = 0; nh2 = 0;
      while (armed === 1'b1 && n < 300) begin
         if (bombX !== 10'(tx) || bombY !== 10'(ty) || bombXS !== 10'd32 ||
             bombYS !== 10'd32 || blast !== 1'b0) bad++;
         nh1 += int'(hit1); nh2 += int'(hit2);
         n++;
         tick();
      end
      check("armed_len", 32'(n), FUSE);
      check("armed_rect", 32'(bad), 0);
      bx = borg(tx); by = borg(ty); bw = bext(tx); bh = bext(ty);
      n = 0; bad = 0;
      while (blast === 1'b1 && n < 300) begin
         if (bombX !== 10'(bx) || bombY !== 10'(by) || bombXS !== 10'(bw) ||
             bombYS !== 10'(bh) || armed !== 1'b0) bad++;
         nh1 += int'(hit1); nh2 += int'(hit2);
         n++;
         tick();
      end
      check("blast_len", 32'(n), BLST);
      check("blast_rect", 32'(bad), 0);
      bad = 0;
      for (int i = 0; i < COOL; i++) begin
         if (armed !== 1'b0 || blast !== 1'b0 || bombX !== 10'd0 || bombY !== 10'd0 ||
             bombXS !== 10'd0 || bombYS !== 10'd0) bad++;
         nh1 += int'(hit1); nh2 += int'(hit2);
         tick();
      end
      check("cool_zero", 32'(bad), 0);
      e1 = touches(int'(p1X), int'(p1Y), tx, ty);
      e2 = touches(int'(p2X), int'(p2Y), tx, ty);
      check("hits1", 32'(nh1), 32'(e1));
      check("hits2", 32'(nh2), 32'(e2));
      h1 = (h1 > e1) ? h1 - e1 : 0;
      h2 = (h2 > e2) ? h2 - e2 : 0;
      check("heart1", 32'(heart1), 32'(h1));
      check("heart2", 32'(heart2), 32'(h2));
      check("game_over", 32'(game_over), (h1 == 0 || h2 == 0) ? 1 : 0);
   endtask

   initial begin
      int n, who;

      do_reset();
      check("rst_armed", 32'(armed), 0);
      check("rst_blast", 32'(blast), 0);
      check("rst_bombX", 32'(bombX), 0);
      check("rst_bombY", 32'(bombY), 0);
      check("rst_bombXS", 32'(bombXS), 0);
      check("rst_bombYS", 32'(bombYS), 0);
      check("rst_owner", 32'(owner), 0);
      check("rst_hit1", 32'(hit1), 0);
      check("rst_hit2", 32'(hit2), 0);
      check("rst_heart1", 32'(heart1), 3);
      check("rst_heart2", 32'(heart2), 3);
      check("rst_game_over", 32'(game_over), 0);

      // Tie right after reset: player 1 first, player 2 queued; a second
      // drop2 edge while pending is absorbed.
      p1X = 10'($urandom_range(0, 1000)); p1Y = 10'($urandom_range(0, 1000));
      p2X = 10'($urandom_range(0, 1000)); p2Y = 10'($urandom_range(0, 1000));
      start_bomb(1'b1, 1'b1);
      press(1'b0, 1'b1);
      run_bomb(0, tile_of(int'(p1X)), tile_of(int'(p1Y)), 1);
      check("queue_idle", 32'(armed), 0);
      tick();
      check("queue_grant", 32'(armed), 1);
      run_bomb(1, tile_of(int'(p2X)), tile_of(int'(p2Y)), 0);
      n = 0;
      repeat (10) begin tick(); n += int'(armed); end
      check("absorbed", 32'(n), 0);

      // Single drop with player 1 standing in the blast, player 2 far away.
      do_reset();
      p1X = 10'd70; p1Y = 10'd100; p2X = 10'd600; p2Y = 10'd400;
      start_bomb(1'b1, 1'b0);
      run_bomb(0, 64, 96, 0);
      n = 0;
      repeat (5) begin tick(); n += int'(armed); end
      check("stay_idle", 32'(n), 0);

      // Clamp at the top-left edge; the owner is hit by its own blast.
      p1X = 10'd600; p1Y = 10'd600; p2X = 10'd35; p2Y = 10'd40;
      start_bomb(1'b0, 1'b1);
      run_bomb(1, 32, 32, 0);

      // Random positions, random requester.
      for (int k = 0; k < 4; k++) begin
         do_reset();
         p1X = 10'($urandom_range(0, 1000)); p1Y = 10'($urandom_range(0, 1000));
         p2X = 10'($urandom_range(0, 1000)); p2Y = 10'($urandom_range(0, 1000));
         who = int'($urandom_range(0, 1));
         if (who == 0) begin
            start_bomb(1'b1, 1'b0);
            run_bomb(0, tile_of(int'(p1X)), tile_of(int'(p1Y)), 0);
         end else begin
            start_bomb(1'b0, 1'b1);
            run_bomb(1, tile_of(int'(p2X)), tile_of(int'(p2Y)), 0);
         end
      end

      // Three blasts on player 1 end the game; later drops are not granted.
      do_reset();
      p1X = 10'd70; p1Y = 10'd100; p2X = 10'd600; p2Y = 10'd600;
      repeat (3) begin
         start_bomb(1'b1, 1'b0);
         run_bomb(0, 64, 96, 0);
      end
      check("go_flag", 32'(game_over), 1);
      press(1'b0, 1'b1);
      n = 0;
      repeat (40) begin tick(); n += int'(armed); end
      check("go_no_grant", 32'(n), 0);
      check("go_heart1", 32'(heart1), 0);
      check("go_heart2", 32'(heart2), 3);

      // Asynchronous reset in the middle of a fuse.
      do_reset();
      p1X = 10'd70; p1Y = 10'd100; p2X = 10'd600; p2Y = 10'd600;
      start_bomb(1'b1, 1'b0);
      run_bomb(0, 64, 96, 0);
      start_bomb(1'b1, 1'b0);
      repeat (10) tick();
      check("pre_rst_armed", 32'(armed), 1);
      #1 Reset = 1'b0;
      #1;
      check("arst_armed", 32'(armed), 0);
      check("arst_bombX", 32'(bombX), 0);
      check("arst_bombXS", 32'(bombXS), 0);
      check("arst_heart1", 32'(heart1), 3);
      check("arst_owner", 32'(owner), 0);
      #3 Reset = 1'b1;
      h1 = 3; h2 = 3;
      n = 0;
      repeat (8) begin tick(); n += int'(armed); end
      check("arst_idle", 32'(n), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bomb_ctrl.md
BOMB_CTRL -- requirements
Module: bomb_ctrl

Interface
REQ-001 Parameters SHALL be: FUSE_FRAMES, default 120, frames from placement to blast; BLAST_FRAMES, default 30, frames the blast is lethal; COOL_FRAMES, default 15, dead frames after a blast; TILE, default 32, tile pitch in pixels.
REQ-002 frame_clk  in  1  sole clock; all state advances on its rising edge.
REQ-003 Reset  in  1  asynchronous, active-low reset.
REQ-004 drop1, drop2  in  1 each  bomb-request levels from player 1 and player 2 (held while the key is down).
REQ-005 p1X, p1Y, p2X, p2Y  in  10 each  player top-left pixel positions; every player sprite is 18x26.
REQ-006 bombX, bombY, bombXS, bombYS  out  10 each  active hazard rectangle (origin and extent).
REQ-007 armed, blast  out  1 each  bomb placed but not yet blown; blast lethal.
REQ-008 owner  out  1  0 = player 1, 1 = player 2; player owning the current bomb.
REQ-009 hit1, hit2  out  1 each  one-cycle damage pulses.
REQ-010 heart1, heart2  out  3 each  remaining lives per player.
REQ-011 game_over  out  1  high when either heart counter is 0.

Function
REQ-012 Each drop input SHALL be edge-detected, and a 0->1 transition SHALL set that player's pending flag one cycle later.
REQ-013 A pending flag SHALL clear only when granted or on reset, and further edges while pending SHALL be absorbed.
REQ-014 The FSM states SHALL be IDLE, ARMED, BLAST and COOL.
REQ-015 In IDLE with any flag pending, the FSM SHALL grant a single pending player and SHALL go to ARMED on the next edge.
REQ-016 When both flags are pending, the grant SHALL go to the player not granted last (round-robin); last_grant resets to player 2, so player 1 wins the first tie.
REQ-017 On grant, the FSM SHALL latch the bomb tile origin as the grantee position rounded down to a TILE multiple, (pX>>5)<<5 and (pY>>5)<<5, and SHALL latch owner.
REQ-018 Requests arriving outside IDLE SHALL stay pending and be serviced on return to IDLE; the next grant SHALL be made in the first IDLE cycle.
REQ-019 A 16-bit frame counter SHALL load 0 on every state entry.
REQ-020 ARMED SHALL go to BLAST when the count reaches FUSE_FRAMES-1, giving exactly FUSE_FRAMES cycles in ARMED.
REQ-021 BLAST SHALL go to COOL after BLAST_FRAMES cycles, and COOL SHALL go to IDLE after COOL_FRAMES cycles.
REQ-022 In ARMED, the rectangle SHALL be the tile itself: bombX/Y = tile origin, bombXS = bombYS = TILE.
REQ-023 In BLAST, the rectangle SHALL be the 3x3-tile square centred on the bomb: origin = tile - TILE, extent = 3*TILE.
REQ-024 In BLAST, the origin SHALL clamp to a minimum of 32 on each axis, with the extent shrunk by the clamped amount so the far edge stays at tile + 2*TILE.
REQ-025 In IDLE and COOL, bombX/Y/XS/YS SHALL all be 0.
REQ-026 armed SHALL be 1 exactly in ARMED, and blast SHALL be 1 exactly in BLAST.
REQ-027 Overlap SHALL be true when the player box [pX, pX+18) x [pY, pY+26) intersects [bombX, bombX+bombXS) x [bombY, bombY+bombYS).
REQ-028 In BLAST, overlap SHALL be evaluated every cycle with 11-bit unsigned arithmetic, so there is no 10-bit wrap.
REQ-029 Each player SHALL receive at most one hit per blast: the first overlapping BLAST cycle pulses hitN for one cycle and sets a per-player sticky flag.
REQ-030 The per-player sticky flags SHALL clear on entry to BLAST.
REQ-031 A hit pulse SHALL decrement the matching heart counter, which saturates at 0; both players MAY be hit in the same cycle, and the owner is not exempt.
REQ-032 While game_over is 1, new grants SHALL be suppressed and pending flags SHALL be held; an in-flight bomb SHALL finish its sequence.

Reset
REQ-033 Asserting Reset low at any time, including mid-ARMED or mid-BLAST, SHALL immediately force IDLE.
REQ-034 Reset SHALL zero the counter, pending flags, sticky flags, owner, hit1/hit2, the rectangle outputs, armed and blast.
REQ-035 Reset SHALL set heart1 = heart2 = 3, last_grant = player 2 and game_over = 0.
REQ-036 On release, operation SHALL resume from IDLE at the first rising edge.

Verification
REQ-037 Single drop: drop1 rises with p1 at (70,100) -> armed for exactly 120 cycles with rectangle (64,96,32,32) -> blast for 30 cycles with rectangle (32,64,96,96) -> 15 idle cycles with zeros -> IDLE.
REQ-038 Tie and queue: drop1 and drop2 rise in the same cycle -> owner 0 served first; player 2 granted on the first IDLE cycle after COOL, with owner 1.
REQ-039 Edge clamp: p2 at (35,40) drops -> blast rectangle (32,32,64,64).
REQ-040 Damage: p1 stands inside the blast for all 30 cycles -> exactly one hit1 pulse, heart1 3->2; p2 outside -> no hit2.
REQ-041 Game over: three successive blasts on p1 -> heart1 = 0 and game_over = 1; a further drop2 stays pending and no grant occurs; heart1 stays at 0 with no wrap.
REQ-042 Async reset: Reset pulsed low for half a cycle mid-ARMED -> armed 0 and outputs zero at once, without waiting for a clock edge; hearts return to 3.
